// File: rtl/game_pkg.sv
// game_pkg: state encoding, World over codes and RGB mask constants
// shared by game_sequencer and its bench.
package game_pkg;

    typedef enum logic [2:0] {
        ST_TITLE    = 3'd0,
        ST_FADEIN   = 3'd1,
        ST_PLAY     = 3'd2,
        ST_DYING    = 3'd3,
        ST_RESPAWN  = 3'd4,
        ST_GAMEOVER = 3'd5,
        ST_WIN      = 3'd6,
        ST_PAUSED   = 3'd7
    } state_e;

    localparam logic [1:0] OVER_PLAYING  = 2'b00;
    localparam logic [1:0] OVER_DEAD     = 2'b01;
    localparam logic [1:0] OVER_WON      = 2'b10;
    localparam logic [1:0] OVER_DEAD_ALT = 2'b11;

    localparam logic [11:0] MASK_FFF = 12'hFFF;
    localparam logic [11:0] MASK_000 = 12'h000;
    localparam logic [11:0] MASK_F00 = 12'hF00;
    localparam logic [11:0] MASK_0F0 = 12'h0F0;
    localparam logic [11:0] MASK_777 = 12'h777;

    function automatic logic [11:0] grey_mask(input logic [3:0] lvl);
        return {lvl, lvl, lvl};
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: registers a level once and flags its rising edge
// for one clk.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d_i;
    end

    assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: title/fade/play/death/respawn/game-over flow for World
// and Output. Define PAUSE_EN to add the pause input and PAUSED state.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int FADE_FRAMES    = 2,
    parameter int BLINK_FRAMES   = 16,
    parameter int RESPAWN_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_frame,
    input  logic        start,
`ifdef PAUSE_EN
    input  logic        pause,
`endif
    input  logic [1:0]  over,
    output logic        world_rstn,
    output logic        world_en,
    output logic [11:0] mask,
    output logic [1:0]  lives,
    output logic [2:0]  state
);

    localparam int TW = 8;
    typedef logic [TW-1:0] tmr_t;
    localparam tmr_t FADE_LAST  = tmr_t'(FADE_FRAMES - 1);
    localparam tmr_t BLINK_LAST = tmr_t'(BLINK_FRAMES - 1);
    localparam tmr_t RESP_LAST  = tmr_t'(RESPAWN_FRAMES - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    logic tick, start_pulse;

    edge_pulse u_frame (.clk, .rst, .d_i(clk_frame), .pulse_o(tick));
    edge_pulse u_start (.clk, .rst, .d_i(start), .pulse_o(start_pulse));

`ifdef PAUSE_EN
    logic pause_pulse;
    edge_pulse u_pause (.clk, .rst, .d_i(pause), .pulse_o(pause_pulse));
`endif

    state_e      state_q, state_d;
    logic [3:0]  lvl_q, lvl_d;
    tmr_t        timer_q, timer_d;
    logic [1:0]  lives_q, lives_d;
    logic        blink_q, blink_d;
    logic        rstn_q, rstn_d;
    logic        en_q, en_d;
    logic [11:0] mask_q, mask_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TITLE;
            lvl_q   <= 4'd0;
            timer_q <= '0;
            lives_q <= 2'd0;
            blink_q <= 1'b0;
            rstn_q  <= 1'b0;
            en_q    <= 1'b0;
            mask_q  <= MASK_FFF;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            timer_q <= timer_d;
            lives_q <= lives_d;
            blink_q <= blink_d;
            rstn_q  <= rstn_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        timer_d = timer_q;
        lives_d = lives_q;
        blink_d = blink_q;
        unique case (state_q)
            ST_TITLE: begin
                if (start_pulse) begin
                    state_d = ST_FADEIN;
                    lives_d = LIVES_INIT;
                    lvl_d   = 4'd0;
                    timer_d = '0;
                end
            end
            ST_FADEIN: begin
                if (tick) begin
                    if (timer_q == FADE_LAST) begin
                        timer_d = '0;
                        if (lvl_q == 4'hF) state_d = ST_PLAY;
                        else               lvl_d   = lvl_q + 4'd1;
                    end else begin
                        timer_d = timer_q + tmr_t'(1);
                    end
                end
            end
            ST_PLAY: begin
                // Death wins over a simultaneous win or pause request.
                if (over == OVER_DEAD || over == OVER_DEAD_ALT) begin
                    state_d = ST_DYING;
                    lvl_d   = 4'hF;
                    timer_d = '0;
                end else if (over == OVER_WON) begin
                    state_d = ST_WIN;
                    timer_d = '0;
                    blink_d = 1'b0;
`ifdef PAUSE_EN
                end else if (pause_pulse) begin
                    state_d = ST_PAUSED;
`endif
                end
            end
            ST_DYING: begin
                if (tick) begin
                    if (timer_q == FADE_LAST) begin
                        timer_d = '0;
                        if (lvl_q != 4'd0) begin
                            lvl_d = lvl_q - 4'd1;
                        end else if (lives_q <= 2'd1) begin
                            state_d = ST_GAMEOVER;
                            lives_d = 2'd0;
                            blink_d = 1'b0;
                        end else begin
                            state_d = ST_RESPAWN;
                            lives_d = lives_q - 2'd1;
                        end
                    end else begin
                        timer_d = timer_q + tmr_t'(1);
                    end
                end
            end
            ST_RESPAWN: begin
                if (tick) begin
                    if (timer_q == RESP_LAST) begin
                        state_d = ST_FADEIN;
                        lvl_d   = 4'd0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + tmr_t'(1);
                    end
                end
            end
            ST_GAMEOVER, ST_WIN: begin
                if (start_pulse) begin
                    state_d = ST_TITLE;
                end else if (tick) begin
                    if (timer_q == BLINK_LAST) begin
                        timer_d = '0;
                        blink_d = ~blink_q;
                    end else begin
                        timer_d = timer_q + tmr_t'(1);
                    end
                end
            end
`ifdef PAUSE_EN
            ST_PAUSED: begin
                if (pause_pulse) state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_TITLE;
        endcase

        rstn_d = 1'b1;
        en_d   = 1'b0;
        mask_d = MASK_FFF;
        unique case (state_d)
            ST_TITLE:    rstn_d = 1'b0;
            ST_FADEIN:   mask_d = grey_mask(lvl_d);
            ST_PLAY:     en_d   = 1'b1;
            ST_DYING:    mask_d = grey_mask(lvl_d);
            ST_RESPAWN: begin
                rstn_d = 1'b0;
                mask_d = MASK_000;
            end
            ST_GAMEOVER: mask_d = blink_d ? MASK_000 : MASK_F00;
            ST_WIN:      mask_d = blink_d ? MASK_000 : MASK_0F0;
            ST_PAUSED:   mask_d = MASK_777;
            default:     mask_d = MASK_FFF;
        endcase
    end

    assign world_rstn = rstn_q;
    assign world_en   = en_q;
    assign mask       = mask_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed game-flow scenarios checked every clk
// against a tick-counting model of the game rules.
module tb_game_sequencer;

    localparam int LIVES = 3;
    localparam int FADE  = 2;
    localparam int BLINK = 16;
    localparam int RESP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_frame;
    logic        start;
    logic [1:0]  over;
`ifdef PAUSE_EN
    logic        pause;
`endif
    logic        world_rstn;
    logic        world_en;
    logic [11:0] mask;
    logic [1:0]  lives;
    logic [2:0]  state;

    int vectors = 0;
    int errors  = 0;

    game_sequencer #(
        .LIVES(LIVES), .FADE_FRAMES(FADE),
        .BLINK_FRAMES(BLINK), .RESPAWN_FRAMES(RESP)
    ) dut (
        .clk(clk), .rst(rst), .clk_frame(clk_frame), .start(start),
`ifdef PAUSE_EN
        .pause(pause),
`endif
        .over(over), .world_rstn(world_rstn), .world_en(world_en),
        .mask(mask), .lives(lives), .state(state)
    );

    always #5 clk = ~clk;

    // Model: phase plus ticks counted since entering that phase.
    int m_st, m_n, m_lives;
    bit pf, ps, pp;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_n = 0; m_lives = 0;
        pf = 0; ps = 0; pp = 0;
    endtask

    task automatic model_step();
        bit tk, sp, pe;
        tk = clk_frame && !pf;
        sp = start && !ps;
        pf = clk_frame;
        ps = start;
        pe = 0;
`ifdef PAUSE_EN
        pe = pause && !pp;
        pp = pause;
`endif
        case (m_st)
            0: if (sp) begin m_st = 1; m_lives = LIVES; m_n = 0; end
            1: if (tk) begin
                m_n++;
                if (m_n == 16 * FADE) begin m_st = 2; m_n = 0; end
            end
            2: if (over == 2'b01 || over == 2'b11) begin m_st = 3; m_n = 0; end
               else if (over == 2'b10) begin m_st = 6; m_n = 0; end
               else if (pe) m_st = 7;
            3: if (tk) begin
                m_n++;
                if (m_n == 16 * FADE) begin
                    m_n = 0;
                    if (m_lives <= 1) begin m_lives = 0; m_st = 5; end
                    else begin m_lives--; m_st = 4; end
                end
            end
            4: if (tk) begin
                m_n++;
                if (m_n == RESP) begin m_st = 1; m_n = 0; end
            end
            5, 6: if (sp) m_st = 0; else if (tk) m_n++;
            7: if (pe) m_st = 2;
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [18:0] model_out();
        logic rn, en;
        logic [11:0] m;
        logic [3:0] l;
        rn = 1; en = 0; m = 12'hFFF; l = 0;
        case (m_st)
            0: rn = 0;
            1: begin l = 4'(m_n / FADE); m = {l, l, l}; end
            2: en = 1;
            3: begin l = 4'(15 - m_n / FADE); m = {l, l, l}; end
            4: begin rn = 0; m = 12'h000; end
            5: m = ((m_n / BLINK) % 2 == 1) ? 12'h000 : 12'hF00;
            6: m = ((m_n / BLINK) % 2 == 1) ? 12'h000 : 12'h0F0;
            7: m = 12'h777;
            default: m = 12'hFFF;
        endcase
        return {rn, en, m, 2'(m_lives), 3'(m_st)};
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            check("cycle", 32'({world_rstn, world_en, mask, lives, state}),
                  32'(model_out()));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk) clk_frame = 1'b1;
            @(negedge clk);
            @(negedge clk) clk_frame = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
    endtask

    task automatic over_pulse(input logic [1:0] v);
        @(negedge clk) over = v;
        @(negedge clk) over = 2'b00;
    endtask

    initial begin
        rst = 1'b0; clk_frame = 1'b0; start = 1'b0; over = 2'b00;
`ifdef PAUSE_EN
        pause = 1'b0;
`endif
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_lives", 32'(lives), 32'd0);
        check("rst_mask", 32'(mask), 32'hFFF);
        check("rst_rstn", 32'(world_rstn), 32'd0);
        check("rst_en", 32'(world_en), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // start and a tick in the same clk: tick must not count
        @(negedge clk) begin start = 1'b1; clk_frame = 1'b1; end
        @(negedge clk);
        @(negedge clk) clk_frame = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk) start = 1'b0;
        check("fade_state", 32'(state), 32'd1);
        check("fade_lives", 32'(lives), 32'd3);
        check("fade_mask0", 32'(mask), 32'h000);
        tick_n(1);
        check("fade_t1", 32'(mask), 32'h000);
        tick_n(1);
        check("fade_t2", 32'(mask), 32'h111);
        tick_n(29);
        check("fade_t31_mask", 32'(mask), 32'hFFF);
        check("fade_t31_state", 32'(state), 32'd1);
        tick_n(1);
        check("play_state", 32'(state), 32'd2);
        check("play_en", 32'(world_en), 32'd1);

        over_pulse(2'b01);
        check("dying_state", 32'(state), 32'd3);
        check("dying_en", 32'(world_en), 32'd0);
        tick_n(32);
        check("resp_state", 32'(state), 32'd4);
        check("resp_lives", 32'(lives), 32'd2);
        check("resp_rstn", 32'(world_rstn), 32'd0);
        tick_n(3);
        check("resp_hold", 32'(state), 32'd4);
        tick_n(1);
        check("resp_exit", 32'(state), 32'd1);

        tick_n(32);
        over_pulse(2'b11);
        tick_n(36);
        check("life1_state", 32'(state), 32'd1);
        check("life1_lives", 32'(lives), 32'd1);
        tick_n(32);
        over_pulse(2'b01);
        tick_n(32);
        check("go_state", 32'(state), 32'd5);
        check("go_lives", 32'(lives), 32'd0);
        check("go_mask0", 32'(mask), 32'hF00);
        tick_n(16);
        check("go_mask1", 32'(mask), 32'h000);
        tick_n(16);
        check("go_mask2", 32'(mask), 32'hF00);
        press();
        check("go_exit", 32'(state), 32'd0);

        press();
        tick_n(32);
        @(negedge clk) begin start = 1'b1; over = 2'b10; end
        @(negedge clk) over = 2'b00;
        check("win_state", 32'(state), 32'd6);
        check("win_mask0", 32'(mask), 32'h0F0);
        repeat (3) @(negedge clk);
        check("win_held", 32'(state), 32'd6);
        tick_n(16);
        check("win_mask1", 32'(mask), 32'h000);
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        press();
        check("win_exit", 32'(state), 32'd0);

        press();
        tick_n(32);
`ifdef PAUSE_EN
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        check("pause_state", 32'(state), 32'd7);
        check("pause_mask", 32'(mask), 32'h777);
        @(negedge clk) over = 2'b01;
        repeat (3) @(negedge clk);
        check("pause_over", 32'(state), 32'd7);
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        @(negedge clk) over = 2'b00;
        check("unpause_die", 32'(state), 32'd3);
`else
        over_pulse(2'b01);
`endif
        tick_n(16);
        check("lvl7_state", 32'(state), 32'd3);
        check("lvl7_mask", 32'(mask), 32'h777);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_lives", 32'(lives), 32'd0);
        check("arst_mask", 32'(mask), 32'hFFF);
        check("arst_rstn", 32'(world_rstn), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
